// File: rtl/pwr_sequencer.sv
// pwr_sequencer: push-button power sequencer driving NUM_RAILS ordered rail enables with fault abort
module pwr_sequencer #(
  parameter int NUM_RAILS   = 2,
  parameter int DEB_CYCLES  = 1048576,
  parameter int STEP_CYCLES = 1048576
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 btn,
  input  logic                 fault,
  output logic [NUM_RAILS-1:0] rail_en,
  output logic                 pwr_good,
  output logic                 busy,
  output logic                 fault_latched
);
  localparam int DW = $clog2(DEB_CYCLES);
  localparam int SW = $clog2(STEP_CYCLES);
  localparam logic [DW-1:0] DEB_MAX  = DW'(DEB_CYCLES - 1);
  localparam logic [SW-1:0] STEP_MAX = SW'(STEP_CYCLES - 1);
  typedef enum logic [2:0] {OFF_REL, OFF_ARM, RAMP_UP, ON_REL, ON_ARM, RAMP_DN} state_t;
  state_t               r_state;
  logic [1:0]           r_btn_sync;
  logic [1:0]           r_flt_sync;
  logic [DW-1:0]        r_deb;
  logic [SW-1:0]        r_step;
  logic                 w_btn;
  logic                 w_flt;
  logic                 w_level;
  logic                 w_deb_done;
  logic                 w_step_done;
  logic                 w_abort;
  logic [NUM_RAILS-1:0] w_up_next;
  logic [NUM_RAILS-1:0] w_dn_next;
  assign w_btn       = r_btn_sync[1];
  assign w_flt       = r_flt_sync[1];
  assign pwr_good    = (r_state == ON_REL) || (r_state == ON_ARM);
  assign busy        = (r_state == RAMP_UP) || (r_state == RAMP_DN);
  assign w_deb_done  = w_level && (r_deb == DEB_MAX);
  assign w_step_done = busy && (r_step == STEP_MAX);
  assign w_abort     = w_flt && ((r_state == RAMP_UP) || pwr_good);
  // rails are always a contiguous run from bit 0, so shifting adds or drops the top rail
  assign w_up_next   = (rail_en << 1) | NUM_RAILS'(1);
  assign w_dn_next   = rail_en >> 1;
  // qualifying button level for the current debounce state; a press is not honoured during a fault
  always_comb begin
    w_level = 1'b0;
    case (r_state)
      OFF_REL, ON_REL: w_level = !w_btn;
      OFF_ARM:         w_level = w_btn && !w_flt;
      ON_ARM:          w_level = w_btn;
      default:         w_level = 1'b0;
    endcase
  end
  // two-flop synchronisers for the asynchronous button and fault pins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_btn_sync <= '0;
      r_flt_sync <= '0;
    end else begin
      r_btn_sync <= {r_btn_sync[0], btn};
      r_flt_sync <= {r_flt_sync[0], fault};
    end
  end
  // sequencing FSM with debounce and step timers; a fault abort overrides the normal transition
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= OFF_REL;
      rail_en       <= '0;
      fault_latched <= 1'b0;
      r_deb         <= '0;
      r_step        <= '0;
    end else begin
      r_deb  <= (w_level && !w_deb_done) ? r_deb + 1'b1 : '0;
      r_step <= (busy && !w_step_done) ? r_step + 1'b1 : '0;
      case (r_state)
        OFF_REL: if (w_deb_done) r_state <= OFF_ARM;
        OFF_ARM: if (w_deb_done) begin
          rail_en       <= NUM_RAILS'(1);
          fault_latched <= 1'b0;
          r_state       <= (NUM_RAILS == 1) ? ON_REL : RAMP_UP;
        end
        RAMP_UP: if (w_step_done) begin
          rail_en <= w_up_next;
          if (w_up_next[NUM_RAILS-1]) r_state <= ON_REL;
        end
        ON_REL: if (w_deb_done) r_state <= ON_ARM;
        ON_ARM: if (w_deb_done) begin
          rail_en <= w_dn_next;
          r_state <= (w_dn_next == '0) ? OFF_REL : RAMP_DN;
        end
        RAMP_DN: if (w_step_done) begin
          rail_en <= w_dn_next;
          if (w_dn_next == '0) r_state <= OFF_REL;
        end
        default: r_state <= OFF_REL;
      endcase
      if (w_abort) begin
        rail_en       <= w_dn_next;
        fault_latched <= 1'b1;
        r_deb         <= '0;
        r_step        <= '0;
        r_state       <= (w_dn_next == '0) ? OFF_REL : RAMP_DN;
      end
    end
  end
endmodule
